id_ex_stage_reg: RTL and testbench

// Parametrised ID->EX pipeline register for the mips32 core.

---
 rtl/id_ex_stage_reg.sv | 149 ++++++++++++++
 tb/tb_id_ex_stage_reg.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage_reg.sv
// ID->EX pipeline register for the mips32 core: valid bit, flush, configurable stall index
// and saturating stall/bubble performance counters.
module id_ex_stage_reg #(
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned ADDR_W  = 5,
   parameter int unsigned ALUOP_W = 8,
   parameter int unsigned STALL_W = 6,
   parameter int unsigned STAGE   = 2,
   parameter int unsigned CNT_W   = 16,
   parameter logic [ALUOP_W-1:0] NOP_ALUOP = '0
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic [STALL_W-1:0] i_stall,
   input  logic               i_flush,
   input  logic               i_clrCnt,
   input  logic               i_id_valid,
   input  logic [ALUOP_W-1:0] i_id_aluOp,
   input  logic [DATA_W-1:0]  i_id_opNum1,
   input  logic [DATA_W-1:0]  i_id_opNum2,
   input  logic [ADDR_W-1:0]  i_id_writeAddr,
   input  logic               i_id_writeReg,
   input  logic               i_id_inDelaySlot,
   input  logic [DATA_W-1:0]  i_id_linkAddr,
   input  logic               i_nextInstInDelaySlot,
   output logic               o_ex_valid,
   output logic [ALUOP_W-1:0] o_ex_aluOp,
   output logic [DATA_W-1:0]  o_ex_opNum1,
   output logic [DATA_W-1:0]  o_ex_opNum2,
   output logic [ADDR_W-1:0]  o_ex_writeAddr,
   output logic               o_ex_writeReg,
   output logic               o_ex_inDelaySlot,
   output logic [DATA_W-1:0]  o_ex_linkAddr,
   output logic               o_inDelaySlot,
   output logic [CNT_W-1:0]   o_stallCnt,
   output logic [CNT_W-1:0]   o_bubbleCnt
);

   typedef enum logic [1:0] {ActFlush, ActAdvance, ActBubble, ActHold} act_e;

   localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

   act_e               w_act;
   logic               w_stall_sat;
   logic               w_bubble_sat;

   logic               r_valid;
   logic [ALUOP_W-1:0] r_aluOp;
   logic [DATA_W-1:0]  r_opNum1;
   logic [DATA_W-1:0]  r_opNum2;
   logic [ADDR_W-1:0]  r_writeAddr;
   logic               r_writeReg;
   logic               r_exInDelaySlot;
   logic [DATA_W-1:0]  r_linkAddr;
   logic               r_inDelaySlot;
   logic [CNT_W-1:0]   r_stallCnt;
   logic [CNT_W-1:0]   r_bubbleCnt;

   // Flush beats every stall pattern; otherwise our stall bit and the downstream bit decide.
   always_comb begin
      w_act = ActAdvance;
      if (i_flush) begin
         w_act = ActFlush;
      end else if (!i_stall[STAGE]) begin
         w_act = ActAdvance;
      end else if (!i_stall[STAGE+1]) begin
         w_act = ActBubble;
      end else begin
         w_act = ActHold;
      end
   end

   assign w_stall_sat  = &r_stallCnt;
   assign w_bubble_sat = &r_bubbleCnt;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_valid         <= 1'b0;
         r_aluOp         <= NOP_ALUOP;
         r_opNum1        <= '0;
         r_opNum2        <= '0;
         r_writeAddr     <= '0;
         r_writeReg      <= 1'b0;
         r_exInDelaySlot <= 1'b0;
         r_linkAddr      <= '0;
         r_inDelaySlot   <= 1'b0;
      end else begin
         unique case (w_act)
            ActFlush, ActBubble: begin
               r_valid         <= 1'b0;
               r_aluOp         <= NOP_ALUOP;
               r_opNum1        <= '0;
               r_opNum2        <= '0;
               r_writeAddr     <= '0;
               r_writeReg      <= 1'b0;
               r_exInDelaySlot <= 1'b0;
               r_linkAddr      <= '0;
               // A bubble keeps the delay-slot feedback; only a flush kills it.
               if (w_act == ActFlush) begin
                  r_inDelaySlot <= 1'b0;
               end
            end
            ActAdvance: begin
               r_valid         <= i_id_valid;
               r_aluOp         <= i_id_aluOp;
               r_opNum1        <= i_id_opNum1;
               r_opNum2        <= i_id_opNum2;
               r_writeAddr     <= i_id_writeAddr;
               r_writeReg      <= i_id_writeReg & i_id_valid;
               r_exInDelaySlot <= i_id_inDelaySlot;
               r_linkAddr      <= i_id_linkAddr;
               r_inDelaySlot   <= i_nextInstInDelaySlot;
            end
            ActHold: begin
            end
            default: begin
            end
         endcase
      end
   end

   // Counters saturate; clrCnt wins over an increment and flush never touches them.
   always_ff @(posedge i_clk) begin
      if (i_rst || i_clrCnt) begin
         r_stallCnt  <= '0;
         r_bubbleCnt <= '0;
      end else begin
         if (w_act == ActHold && !w_stall_sat) begin
            r_stallCnt <= r_stallCnt + CntOne;
         end
         if (w_act == ActBubble && !w_bubble_sat) begin
            r_bubbleCnt <= r_bubbleCnt + CntOne;
         end
      end
   end

   assign o_ex_valid       = r_valid;
   assign o_ex_aluOp       = r_aluOp;
   assign o_ex_opNum1      = r_opNum1;
   assign o_ex_opNum2      = r_opNum2;
   assign o_ex_writeAddr   = r_writeAddr;
   assign o_ex_writeReg    = r_writeReg;
   assign o_ex_inDelaySlot = r_exInDelaySlot;
   assign o_ex_linkAddr    = r_linkAddr;
   assign o_inDelaySlot    = r_inDelaySlot;
   assign o_stallCnt       = r_stallCnt;
   assign o_bubbleCnt      = r_bubbleCnt;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Randomized bench for id_ex_stage_reg: two instances (16-bit and 4-bit counters) checked
// every cycle against a behavioural model, plus literal checks of the directed scenarios.
module tb_id_ex_stage_reg;

   logic        clk = 1'b0;
   logic        rst, flush, clrCnt, id_valid, id_writeReg, id_inDelaySlot, nextInst;
   logic [5:0]  stall;
   logic [7:0]  id_aluOp;
   logic [31:0] id_opNum1, id_opNum2, id_linkAddr;
   logic [4:0]  id_writeAddr;

   logic        a_valid, a_writeReg, a_exInDs, a_inDs;
   logic [7:0]  a_aluOp;
   logic [31:0] a_op1, a_op2, a_link;
   logic [4:0]  a_wa;
   logic [15:0] a_sc, a_bc;

   logic        b_valid, b_writeReg, b_exInDs, b_inDs;
   logic [7:0]  b_aluOp;
   logic [31:0] b_op1, b_op2, b_link;
   logic [4:0]  b_wa;
   logic [3:0]  b_sc, b_bc;

   int errors = 0;
   int checks = 0;
   bit chk_en = 1'b0;

   // model state
   bit          m_valid, m_wr, m_exInDs, m_inDs;
   logic [7:0]  m_alu;
   logic [31:0] m_op1, m_op2, m_link;
   logic [4:0]  m_wa;
   int          m_sc, m_bc, m_sc4, m_bc4;

   always #5 clk = ~clk;

   id_ex_stage_reg u_dut_a (
      .i_clk(clk), .i_rst(rst), .i_stall(stall), .i_flush(flush), .i_clrCnt(clrCnt),
      .i_id_valid(id_valid), .i_id_aluOp(id_aluOp), .i_id_opNum1(id_opNum1),
      .i_id_opNum2(id_opNum2), .i_id_writeAddr(id_writeAddr), .i_id_writeReg(id_writeReg),
      .i_id_inDelaySlot(id_inDelaySlot), .i_id_linkAddr(id_linkAddr),
      .i_nextInstInDelaySlot(nextInst),
      .o_ex_valid(a_valid), .o_ex_aluOp(a_aluOp), .o_ex_opNum1(a_op1), .o_ex_opNum2(a_op2),
      .o_ex_writeAddr(a_wa), .o_ex_writeReg(a_writeReg), .o_ex_inDelaySlot(a_exInDs),
      .o_ex_linkAddr(a_link), .o_inDelaySlot(a_inDs), .o_stallCnt(a_sc), .o_bubbleCnt(a_bc)
   );

   id_ex_stage_reg #(.CNT_W(4)) u_dut_b (
      .i_clk(clk), .i_rst(rst), .i_stall(stall), .i_flush(flush), .i_clrCnt(clrCnt),
      .i_id_valid(id_valid), .i_id_aluOp(id_aluOp), .i_id_opNum1(id_opNum1),
      .i_id_opNum2(id_opNum2), .i_id_writeAddr(id_writeAddr), .i_id_writeReg(id_writeReg),
      .i_id_inDelaySlot(id_inDelaySlot), .i_id_linkAddr(id_linkAddr),
      .i_nextInstInDelaySlot(nextInst),
      .o_ex_valid(b_valid), .o_ex_aluOp(b_aluOp), .o_ex_opNum1(b_op1), .o_ex_opNum2(b_op2),
      .o_ex_writeAddr(b_wa), .o_ex_writeReg(b_writeReg), .o_ex_inDelaySlot(b_exInDs),
      .o_ex_linkAddr(b_link), .o_inDelaySlot(b_inDs), .o_stallCnt(b_sc), .o_bubbleCnt(b_bc)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int sat_inc(input int v, input int maxv);
      return (v < maxv) ? v + 1 : v;
   endfunction

   task automatic nop_image();
      m_valid = 0; m_alu = 8'h00; m_op1 = '0; m_op2 = '0; m_wa = '0;
      m_wr = 0; m_exInDs = 0; m_link = '0;
   endtask

   // Model: one step per rising edge from the inputs stable at that edge.
   always @(posedge clk) begin
      if (rst) begin
         nop_image();
         m_inDs = 0; m_sc = 0; m_bc = 0; m_sc4 = 0; m_bc4 = 0;
      end else begin
         if (flush) begin
            nop_image();
            m_inDs = 0;
         end else if (!stall[2]) begin
            m_valid = id_valid; m_alu = id_aluOp; m_op1 = id_opNum1; m_op2 = id_opNum2;
            m_wa = id_writeAddr; m_wr = id_writeReg && id_valid; m_exInDs = id_inDelaySlot;
            m_link = id_linkAddr; m_inDs = nextInst;
         end else if (!stall[3]) begin
            nop_image();
            m_bc = sat_inc(m_bc, 65535); m_bc4 = sat_inc(m_bc4, 15);
         end else begin
            m_sc = sat_inc(m_sc, 65535); m_sc4 = sat_inc(m_sc4, 15);
         end
         if (clrCnt) begin
            m_sc = 0; m_bc = 0; m_sc4 = 0; m_bc4 = 0;
         end
      end
   end

   // Compare process: both instances against the model on every falling edge.
   always @(negedge clk) begin
      if (chk_en) begin
         chk("a_valid", a_valid, m_valid);     chk("b_valid", b_valid, m_valid);
         chk("a_aluOp", a_aluOp, m_alu);       chk("b_aluOp", b_aluOp, m_alu);
         chk("a_opNum1", a_op1, m_op1);        chk("b_opNum1", b_op1, m_op1);
         chk("a_opNum2", a_op2, m_op2);        chk("b_opNum2", b_op2, m_op2);
         chk("a_writeAddr", a_wa, m_wa);       chk("b_writeAddr", b_wa, m_wa);
         chk("a_writeReg", a_writeReg, m_wr);  chk("b_writeReg", b_writeReg, m_wr);
         chk("a_exInDs", a_exInDs, m_exInDs);  chk("b_exInDs", b_exInDs, m_exInDs);
         chk("a_linkAddr", a_link, m_link);    chk("b_linkAddr", b_link, m_link);
         chk("a_inDs", a_inDs, m_inDs);        chk("b_inDs", b_inDs, m_inDs);
         chk("a_stallCnt", a_sc, 64'(m_sc));   chk("b_stallCnt", b_sc, 64'(m_sc4));
         chk("a_bubbleCnt", a_bc, 64'(m_bc));  chk("b_bubbleCnt", b_bc, 64'(m_bc4));
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic set_id(input logic v, input logic [7:0] op, input logic [31:0] o1,
                         input logic [31:0] o2, input logic [4:0] wa, input logic wr);
      id_valid = v; id_aluOp = op; id_opNum1 = o1; id_opNum2 = o2;
      id_writeAddr = wa; id_writeReg = wr;
   endtask

   initial begin
      rst = 1; flush = 0; clrCnt = 0; stall = 6'b0; nextInst = 1;
      set_id(1, 8'hA5, 32'hDEAD_BEEF, 32'h1234_5678, 5'd17, 1);
      id_inDelaySlot = 1; id_linkAddr = 32'hCAFE_0000;
      // 1: reset with nonzero ID inputs
      cyc(2);
      chk_en = 1'b1;
      chk("rst_aluOp", a_aluOp, 8'h00);   chk("rst_valid", a_valid, 1'b0);
      chk("rst_opNum1", a_op1, 32'h0);    chk("rst_inDs", a_inDs, 1'b0);
      chk("rst_stallCnt", a_sc, 16'h0);   chk("rst_bubbleCnt", a_bc, 16'h0);

      // 2 + 8: advance with nextInstInDelaySlot=1
      rst = 0; id_inDelaySlot = 0; id_linkAddr = 32'h0;
      set_id(1, 8'h21, 32'h5, 32'h7, 5'd3, 1);
      cyc(1);
      chk("adv_aluOp", a_aluOp, 8'h21);   chk("adv_opNum1", a_op1, 32'h5);
      chk("adv_opNum2", a_op2, 32'h7);    chk("adv_writeAddr", a_wa, 5'd3);
      chk("adv_writeReg", a_writeReg, 1'b1); chk("adv_valid", a_valid, 1'b1);
      chk("adv_inDs", a_inDs, 1'b1);

      // 3: bubbles
      stall = 6'b000100;
      cyc(3);
      chk("bub_aluOp", a_aluOp, 8'h00);   chk("bub_valid", a_valid, 1'b0);
      chk("bub_cnt", a_bc, 16'd3);        chk("bub_inDs", a_inDs, 1'b1);

      // 4: reload, hold twice, then new data loads
      stall = 6'b0;
      cyc(1);
      stall = 6'b001100;
      set_id(1, 8'h33, 32'h9, 32'hB, 5'd4, 1);
      cyc(2);
      chk("hold_aluOp", a_aluOp, 8'h21);  chk("hold_cnt", a_sc, 16'd2);
      stall = 6'b0;
      cyc(1);
      chk("rel_aluOp", a_aluOp, 8'h33);   chk("rel_opNum1", a_op1, 32'h9);

      // 5: flush over a hold
      flush = 1; stall = 6'b001100;
      cyc(1);
      flush = 0;
      chk("fl_aluOp", a_aluOp, 8'h00);    chk("fl_inDs", a_inDs, 1'b0);
      chk("fl_stallCnt", a_sc, 16'd2);    chk("fl_bubbleCnt", a_bc, 16'd3);

      // 7: invalid slot never writes
      stall = 6'b0; set_id(0, 8'h44, 32'h1, 32'h2, 5'd9, 1);
      cyc(1);
      chk("inv_valid", a_valid, 1'b0);    chk("inv_writeReg", a_writeReg, 1'b0);

      // 6: saturation of the 4-bit counter, then clear during hold
      stall = 6'b001100;
      cyc(20);
      chk("sat4_stallCnt", b_sc, 4'hF);   chk("sat16_stallCnt", a_sc, 16'd22);
      clrCnt = 1;
      cyc(1);
      clrCnt = 0;
      chk("clr_stallCnt4", b_sc, 4'h0);   chk("clr_stallCnt16", a_sc, 16'h0);

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         int sel;
         sel = $urandom_range(0, 9);
         stall = 6'($urandom);
         stall[2] = (sel >= 5);
         stall[3] = (sel >= 8);
         flush = ($urandom_range(0, 15) == 0);
         clrCnt = ($urandom_range(0, 63) == 0);
         rst = ($urandom_range(0, 199) == 0);
         set_id(1'($urandom), 8'($urandom), $urandom, $urandom, 5'($urandom), 1'($urandom));
         id_inDelaySlot = 1'($urandom); id_linkAddr = $urandom; nextInst = 1'($urandom);
         cyc(1);
      end
      rst = 0; flush = 0; clrCnt = 0;
      cyc(1);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
